// File: rtl/elastic_pipeline_pkg.sv
// Shared helpers for the elastic valid/ready pipeline.
// Sizing function for the occupancy counter; imported by the top.
package elastic_pipeline_pkg;

  // The counter has to reach N+1 when the skid entry is present.
  function automatic int occ_width(input int stages);
    return $clog2(stages + 2);
  endfunction

endpackage

// File: rtl/elastic_pipeline_stage.sv
// One elastic stage: a valid+data register plus its ready term.
// Ports: clk, reset_n, prev_valid/prev_data (from upstream), next_ready
// (from downstream), valid/data (registered), ready (to upstream).
module elastic_pipeline_stage #(
  parameter int BIT_WIDTH = 10
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 prev_valid,
  input  logic [BIT_WIDTH-1:0] prev_data,
  input  logic                 next_ready,
  output logic                 valid,
  output logic [BIT_WIDTH-1:0] data,
  output logic                 ready
);

  // An empty stage can always take a beat, which collapses bubbles.
  assign ready = !valid || next_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (ready) begin
      valid <= prev_valid;
      if (prev_valid) begin
        data <= prev_data;
      end
    end
  end

endmodule

// File: rtl/elastic_pipeline.sv
// Valid/ready pipeline of NUMBER_OF_STAGES registers with backpressure.
// Ports: clk, reset_n (async, active-low), in_valid/in_ready/in_data,
// out_valid/out_ready/out_data, occupancy (beats currently held).
// Macro ELASTIC_PIPELINE_SKID_EN adds a one-entry input skid so that
// in_ready is a flop output with no path from out_ready.
module elastic_pipeline
  import elastic_pipeline_pkg::*;
#(
  parameter int BIT_WIDTH        = 10,
  parameter int NUMBER_OF_STAGES = 5
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BIT_WIDTH-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BIT_WIDTH-1:0] out_data,
  output logic [$clog2(NUMBER_OF_STAGES+2)-1:0] occupancy
);

  localparam int N     = NUMBER_OF_STAGES;
  localparam int OCC_W = occ_width(N);

  logic                 front_ready;
  logic                 src_valid;
  logic [BIT_WIDTH-1:0] src_data;

`ifdef ELASTIC_PIPELINE_SKID_EN
  logic                 skid_valid;
  logic                 skid_valid_nx;
  logic [BIT_WIDTH-1:0] skid_data;
  logic                 rdy_q;
  logic                 accept;

  // rdy_q mirrors !skid_valid but resets to 0 so that in_ready
  // stays low while reset_n is asserted.
  assign in_ready  = rdy_q;
  assign accept    = in_valid && rdy_q;
  assign src_valid = skid_valid || accept;
  assign src_data  = skid_valid ? skid_data : in_data;

  always_comb begin
    skid_valid_nx = skid_valid;
    if (skid_valid) begin
      if (front_ready) begin
        skid_valid_nx = 1'b0;
      end
    end else if (accept && !front_ready) begin
      skid_valid_nx = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      skid_valid <= 1'b0;
      skid_data  <= '0;
      rdy_q      <= 1'b0;
    end else begin
      skid_valid <= skid_valid_nx;
      rdy_q      <= !skid_valid_nx;
      if (!skid_valid && accept && !front_ready) begin
        skid_data <= in_data;
      end
    end
  end
`else
  assign in_ready  = front_ready && reset_n;
  assign src_valid = in_valid;
  assign src_data  = in_data;
`endif

  if (N == 0) begin : g_pass
    assign front_ready = out_ready;
    assign out_valid   = src_valid;
    assign out_data    = src_data;
  end else begin : g_chain
    logic [N-1:0]         v;
    logic [BIT_WIDTH-1:0] d [N];
    logic [N:0]           rdy;

    assign rdy[N] = out_ready;

    for (genvar k = 0; k < N; k++) begin : g_stage
      logic                 pv;
      logic [BIT_WIDTH-1:0] pd;

      if (k == 0) begin : g_head
        assign pv = src_valid;
        assign pd = src_data;
      end else begin : g_link
        assign pv = v[k-1];
        assign pd = d[k-1];
      end

      elastic_pipeline_stage #(
        .BIT_WIDTH(BIT_WIDTH)
      ) u_stage (
        .clk       (clk),
        .reset_n   (reset_n),
        .prev_valid(pv),
        .prev_data (pd),
        .next_ready(rdy[k+1]),
        .valid     (v[k]),
        .data      (d[k]),
        .ready     (rdy[k])
      );
    end

    assign front_ready = rdy[0];
    assign out_valid   = v[N-1];
    assign out_data    = d[N-1];
  end

  logic             in_xfer;
  logic             out_xfer;
  logic [OCC_W-1:0] occ_q;

  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;
  assign occupancy = occ_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      occ_q <= '0;
    end else begin
      unique case ({in_xfer, out_xfer})
        2'b10:   occ_q <= occ_q + OCC_W'(1);
        2'b01:   occ_q <= occ_q - OCC_W'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end

endmodule

// File: tb/tb_elastic_pipeline.sv
// Bench for elastic_pipeline against a beat-queue reference model.
// Also exercises a NUMBER_OF_STAGES=0 instance as a pass-through.
module tb_elastic_pipeline;

  localparam int W  = 10;
  localparam int N  = 5;
  localparam int OW = $clog2(N + 2);
`ifdef ELASTIC_PIPELINE_SKID_EN
  localparam bit SKID = 1'b1;
  localparam int CAP  = N + 1;
`else
  localparam bit SKID = 1'b0;
  localparam int CAP  = N;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [OW-1:0] occupancy;

  logic          pt_in_ready;
  logic          pt_out_valid;
  logic [W-1:0]  pt_out_data;
  logic [0:0]    pt_occupancy;

  elastic_pipeline #(
    .BIT_WIDTH(W),
    .NUMBER_OF_STAGES(N)
  ) u_dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .occupancy(occupancy)
  );

  elastic_pipeline #(
    .BIT_WIDTH(W),
    .NUMBER_OF_STAGES(0)
  ) u_pass (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (pt_in_ready),
    .in_data  (in_data),
    .out_valid(pt_out_valid),
    .out_ready(out_ready),
    .out_data (pt_out_data),
    .occupancy(pt_occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] data;
    int           acc;
  } beat_t;

  beat_t        q[$];
  int           checks   = 0;
  int           failures = 0;
  int           edge_n   = 0;
  int           since    = 0;
  int           out_cnt  = 0;
  logic [W-1:0] last_out;
  logic         last_ir;
  logic         prev_ov;
  logic         prev_or;
  logic [W-1:0] prev_od;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Model: a beat accepted at edge a reaches the output after edge
  // a+N-1, and only once every older beat has left.
  task automatic run_cycle(input logic iv, input logic [W-1:0] d,
                           input logic ordy, output logic acc);
    logic exp_ir;
    logic exp_ov;
    logic out_x;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    #1;
    if (SKID) exp_ir = (since >= 1) && (q.size() <= N);
    else      exp_ir = (q.size() < N) || ordy;
    exp_ov = (q.size() > 0) && (edge_n >= q[0].acc + N - 1);
    check("in_ready", 32'(in_ready), 32'(exp_ir));
    check("out_valid", 32'(out_valid), 32'(exp_ov));
    if (exp_ov) check("out_data", 32'(out_data), 32'(q[0].data));
    check("occupancy", 32'(occupancy), 32'(q.size()));
    if (prev_ov && !prev_or) begin
      check("hold_valid", 32'(out_valid), 32'(1));
      check("hold_data", 32'(out_data), 32'(prev_od));
    end
`ifndef ELASTIC_PIPELINE_SKID_EN
    check("pt_out_valid", 32'(pt_out_valid), 32'(iv));
    check("pt_out_data", 32'(pt_out_data), 32'(d));
    check("pt_in_ready", 32'(pt_in_ready), 32'(ordy));
    check("pt_occupancy", 32'(pt_occupancy), 32'(0));
`endif
    acc   = iv && exp_ir;
    out_x = exp_ov && ordy;
    last_ir = in_ready;
    if (out_valid && ordy) begin
      out_cnt++;
      last_out = out_data;
    end
    prev_ov = out_valid;
    prev_or = ordy;
    prev_od = out_data;
    @(posedge clk);
    edge_n++;
    since++;
    if (out_x) void'(q.pop_front());
    if (acc) q.push_back('{d, edge_n});
    #1;
  endtask

  task automatic offer(input logic [W-1:0] d, input logic ordy);
    logic acc;
    acc = 1'b0;
    for (int t = 0; t < 40 && !acc; t++) run_cycle(1'b1, d, ordy, acc);
    if (!acc) check("offer_timeout", 32'(0), 32'(1));
  endtask

  task automatic drain();
    logic acc;
    for (int t = 0; t < 100 && q.size() > 0; t++)
      run_cycle(1'b0, '0, 1'b1, acc);
    check("drain_occ", 32'(occupancy), 32'(0));
  endtask

  initial begin
    logic         acc;
    logic         pend;
    logic         iv;
    logic [W-1:0] d;
    int           n_acc;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    prev_ov   = 1'b0;
    prev_or   = 1'b0;
    prev_od   = '0;
    last_out  = '0;
    last_ir   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'(0));
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_out_data", 32'(out_data), 32'(0));
    check("rst_occupancy", 32'(occupancy), 32'(0));
    check("rst_pt_in_ready", 32'(pt_in_ready), 32'(0));
    reset_n = 1'b1;
    since   = 0;

    for (int i = 1; i <= 5; i++) offer(W'(i), 1'b1);
    drain();

    n_acc = 0;
    pend  = 1'b0;
    for (int k = 0; k < 6; k++) begin
      run_cycle(1'b1, W'(16 + k), 1'b0, acc);
      if (last_ir) n_acc++;
      pend = !acc;
    end
    check("stall_accepts", 32'(n_acc), 32'(CAP));
    check("stall_occ", 32'(occupancy), 32'(CAP));
    check("stall_head", 32'(out_data), 32'(16));
    run_cycle(pend, W'(21), 1'b1, acc);
    check("pulse_occ", 32'(occupancy), 32'(N));
    drain();

    pend = 1'b0;
    d    = '0;
    iv   = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!pend) begin
        iv = (c % 2) == 0;
        d  = W'($urandom);
      end
      run_cycle(iv, d, $urandom_range(0, 9) < 3, acc);
      pend = iv && !acc;
    end
    if (pend) offer(d, 1'b1);
    drain();

    for (int i = 0; i < 3; i++) run_cycle(1'b1, W'(48 + i), 1'b0, acc);
    check("pre_rst_occ", 32'(occupancy), 32'(3));
    in_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'(0));
    check("mid_rst_occ", 32'(occupancy), 32'(0));
    check("mid_rst_in_ready", 32'(in_ready), 32'(0));
    q.delete();
    prev_ov = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    since   = 0;
    out_cnt = 0;
    offer(W'(170), 1'b1);
    drain();
    check("post_rst_count", 32'(out_cnt), 32'(1));
    check("post_rst_first", 32'(last_out), 32'(170));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
